// File: rtl/hazard_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : hazard_ctrl                                                  |
// | Description : Stall/forwarding scheduler for a five-stage MIPS pipeline.   |
// |               Define HAZARD_MD_EN to build the mult/div busy tracking.     |
// | Revision    : 1.0                                                          |
// +----------------------------------------------------------------------------+
module hazard_ctrl (
  input  logic       clk,
  input  logic       rst,
  input  logic [4:0] ra1D,
  input  logic [4:0] ra2D,
  input  logic [4:0] waD,
  input  logic [2:0] resD,
  input  logic [1:0] tuse1D,
  input  logic [1:0] tuse2D,
  input  logic       mdstartD,
  input  logic       mddivD,
  input  logic       mduseD,
  input  logic       excreq,
  output logic       stall,
  output logic       Eclr,
  output logic [1:0] fwdD1,
  output logic [1:0] fwdD2,
  output logic [1:0] fwdE1,
  output logic [1:0] fwdE2,
  output logic [1:0] fwdM2,
  output logic       mdbusy
);

  localparam logic [2:0] c_RES_NW  = 3'd0;
  localparam logic [2:0] c_RES_ALU = 3'd1;
  localparam logic [2:0] c_RES_DM  = 3'd2;
  localparam logic [2:0] c_RES_PC  = 3'd3;
  localparam logic [2:0] c_RES_MD  = 3'd4;

  logic [4:0] r_ra1E, r_ra2E, r_waE, r_ra2M, r_waM, r_waW;
  logic [2:0] r_resE, r_resM, r_resW;
  logic [1:0] w_tnewE, w_tnewM;
  logic       w_stall_raw, w_mdstall, w_mdbusy_raw;
  logic       w_okE, w_okM, w_okW;

  function automatic logic f_hazard(input logic [4:0] ra, input logic [1:0] tuse,
                                    input logic [4:0] wa_e, input logic [1:0] tn_e,
                                    input logic [4:0] wa_m, input logic [1:0] tn_m);
    return (ra != 5'd0) && (tuse != 2'd3) &&
           (((ra == wa_e) && (tn_e > tuse)) || ((ra == wa_m) && (tn_m > tuse)));
  endfunction

  function automatic logic [1:0] f_fwd(input logic [4:0] ra,
                                       input logic [4:0] wa_e, input logic ok_e,
                                       input logic [4:0] wa_m, input logic ok_m,
                                       input logic [4:0] wa_w, input logic ok_w);
    logic [1:0] sel;
    sel = 2'd0;
    if (ra != 5'd0) begin
      if (ok_e && (ra == wa_e))      sel = 2'd1;
      else if (ok_m && (ra == wa_m)) sel = 2'd2;
      else if (ok_w && (ra == wa_w)) sel = 2'd3;
    end
    return sel;
  endfunction

  always_comb begin
    w_tnewE = 2'd0;
    case (r_resE)
      c_RES_ALU: w_tnewE = 2'd1;
      c_RES_DM:  w_tnewE = 2'd2;
      c_RES_MD:  w_tnewE = 2'd1;
      default:   w_tnewE = 2'd0;
    endcase
    w_tnewM = (r_resM == c_RES_DM) ? 2'd1 : 2'd0;
  end

  // Only a PC-type result (jal) is ready while still in E.
  assign w_okE = (r_resE == c_RES_PC);
  assign w_okM = (r_resM != c_RES_NW) && (w_tnewM == 2'd0);
  assign w_okW = (r_resW != c_RES_NW);

  assign w_stall_raw = f_hazard(ra1D, tuse1D, r_waE, w_tnewE, r_waM, w_tnewM) ||
                       f_hazard(ra2D, tuse2D, r_waE, w_tnewE, r_waM, w_tnewM) ||
                       w_mdstall;

  always_ff @(posedge clk) begin
    if (rst || excreq) begin
      r_ra1E <= 5'd0; r_ra2E <= 5'd0; r_waE <= 5'd0; r_resE <= c_RES_NW;
      r_ra2M <= 5'd0; r_waM  <= 5'd0; r_resM <= c_RES_NW;
      r_waW  <= 5'd0; r_resW <= c_RES_NW;
    end else begin
      r_ra2M <= r_ra2E; r_waM <= r_waE; r_resM <= r_resE;
      r_waW  <= r_waM;  r_resW <= r_resM;
      if (w_stall_raw) begin
        r_ra1E <= 5'd0; r_ra2E <= 5'd0; r_waE <= 5'd0; r_resE <= c_RES_NW;
      end else begin
        r_ra1E <= ra1D; r_ra2E <= ra2D; r_waE <= waD; r_resE <= resD;
      end
    end
  end

`ifdef HAZARD_MD_EN
  logic       r_mdstartE, r_mddivE;
  logic [3:0] r_mdcnt;

  always_ff @(posedge clk) begin
    if (rst || excreq || w_stall_raw) begin
      r_mdstartE <= 1'b0;
      r_mddivE   <= 1'b0;
    end else begin
      r_mdstartE <= mdstartD;
      r_mddivE   <= mddivD;
    end
  end

  // A started operation runs to completion even across an exception.
  always_ff @(posedge clk) begin
    if (rst)
      r_mdcnt <= 4'd0;
    else if (r_mdstartE && !excreq)
      r_mdcnt <= r_mddivE ? 4'd10 : 4'd5;
    else if (r_mdcnt != 4'd0)
      r_mdcnt <= r_mdcnt - 4'd1;
  end

  assign w_mdbusy_raw = (r_mdcnt != 4'd0) || r_mdstartE;
  assign w_mdstall    = mduseD && w_mdbusy_raw;
`else
  logic w_unused_md;
  assign w_unused_md  = ^{mdstartD, mddivD, mduseD};
  assign w_mdbusy_raw = 1'b0;
  assign w_mdstall    = 1'b0;
`endif

  assign stall  = !rst && w_stall_raw;
  assign Eclr   = stall;
  assign mdbusy = !rst && w_mdbusy_raw;
  assign fwdD1  = rst ? 2'd0 : f_fwd(ra1D, r_waE, w_okE, r_waM, w_okM, r_waW, w_okW);
  assign fwdD2  = rst ? 2'd0 : f_fwd(ra2D, r_waE, w_okE, r_waM, w_okM, r_waW, w_okW);
  assign fwdE1  = rst ? 2'd0 : f_fwd(r_ra1E, 5'd0, 1'b0, r_waM, w_okM, r_waW, w_okW);
  assign fwdE2  = rst ? 2'd0 : f_fwd(r_ra2E, 5'd0, 1'b0, r_waM, w_okM, r_waW, w_okW);
  assign fwdM2  = rst ? 2'd0 : f_fwd(r_ra2M, 5'd0, 1'b0, 5'd0, 1'b0, r_waW, w_okW);

endmodule
`default_nettype wire
